ps2_scancode_rx: RTL



---
 rtl/ps2_scancode_rx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 keyboard receiver: conditions the raw lines, frames 11-bit words and turns make/break/E0 sequences into one key_valid per press.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames whose odd parity is wrong.
module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_valid,
    output logic       frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] BYTE_EXT   = 8'hE0;
    localparam logic [7:0] BYTE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Synchronizers idle high, matching an undriven open-collector PS/2 bus
    logic [1:0]    r_clk_sync;
    logic [1:0]    r_data_sync;
    logic          w_clk_s;
    logic          w_data_s;

    logic          r_filt_clk;
    logic [FW-1:0] r_filt_cnt;
    logic          w_filt_flip;
    logic          w_bit_event;

    state_t        r_state;
    state_t        w_state_next;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic          w_timeout;
    logic          w_accept;
    logic          w_err;
    logic          w_parity_ok;

    logic          r_ext_pending;
    logic          r_break_pending;
    logic          r_held_valid;
    logic [7:0]    r_held_code;
    logic          r_held_ext;
    logic          w_held_match;

    logic [7:0]    r_key_code;
    logic          r_key_extended;
    logic          r_key_valid;
    logic          r_frame_error;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    // Filtered clock only follows the synchronized line after FILTER_LEN consecutive differing samples
    assign w_filt_flip = (w_clk_s != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
    assign w_bit_event = w_filt_flip && r_filt_clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_filt_clk) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_filt_clk <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (w_bit_event && (r_state == S_PARITY)) begin
            r_parity <= w_data_s;
        end
    end

    assign w_parity_ok = ^{r_shift, r_parity};
`else
    assign w_parity_ok = 1'b1;
`endif

    // A bit event in the same cycle always beats the timeout
    assign w_timeout = (r_state != S_IDLE) && !w_bit_event &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_bit_event && !w_data_s) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_event && (r_bit_cnt == 3'd7)) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_bit_event) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_event) begin
                    w_state_next = S_IDLE;
                    if (w_data_s && w_parity_ok) begin
                        w_accept = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_err        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) || w_bit_event) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_bit_event && (r_state == S_IDLE)) begin
                r_bit_cnt <= '0;
            end else if (w_bit_event && (r_state == S_DATA)) begin
                r_shift   <= {w_data_s, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign w_held_match = r_held_valid && (r_shift == r_held_code) &&
                          (r_ext_pending == r_held_ext);

    // Byte decoder: prefixes arm pending flags, anything else resolves them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext_pending   <= 1'b0;
            r_break_pending <= 1'b0;
            r_held_valid    <= 1'b0;
            r_held_code     <= '0;
            r_held_ext      <= 1'b0;
            r_key_code      <= '0;
            r_key_extended  <= 1'b0;
            r_key_valid     <= 1'b0;
            r_frame_error   <= 1'b0;
        end else begin
            r_key_valid   <= 1'b0;
            r_frame_error <= w_err;
            if (w_timeout) begin
                r_ext_pending   <= 1'b0;
                r_break_pending <= 1'b0;
            end else if (w_accept) begin
                if (r_shift == BYTE_EXT) begin
                    r_ext_pending <= 1'b1;
                end else if (r_shift == BYTE_BREAK) begin
                    r_break_pending <= 1'b1;
                end else begin
                    r_ext_pending   <= 1'b0;
                    r_break_pending <= 1'b0;
                    if (r_break_pending) begin
                        if (w_held_match) begin
                            r_held_valid <= 1'b0;
                        end
                    end else if (!w_held_match) begin
                        r_key_code     <= r_shift;
                        r_key_extended <= r_ext_pending;
                        r_held_code    <= r_shift;
                        r_held_ext     <= r_ext_pending;
                        r_held_valid   <= 1'b1;
                        r_key_valid    <= 1'b1;
                    end
                end
            end
        end
    end

    assign key_code     = r_key_code;
    assign key_extended = r_key_extended;
    assign key_valid    = r_key_valid;
    assign frame_error  = r_frame_error;

endmodule
